// File: rtl/dcache_pkg.sv
// Shared types and geometry helpers for the direct-mapped write-through data cache.
// Optional statistics counters are enabled with DCACHE_STATS_EN.
package dcache_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REFILL = 2'd1,
        WRITE  = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int DEF_XLEN           = 32;
    localparam int DEF_NUM_LINES      = 8;
    localparam int DEF_WORDS_PER_LINE = 4;

    function automatic int off_w(input int words_per_line);
        return $clog2(words_per_line);
    endfunction

    function automatic int idx_w(input int num_lines);
        return $clog2(num_lines);
    endfunction

    function automatic int tag_w(input int xlen, input int num_lines, input int words_per_line);
        return xlen - 2 - $clog2(num_lines) - $clog2(words_per_line);
    endfunction

    localparam int DEF_TAG_W = tag_w(DEF_XLEN, DEF_NUM_LINES, DEF_WORDS_PER_LINE);

    // One cache line at the default geometry.
    typedef struct packed {
        logic                                            valid;
        logic [DEF_TAG_W-1:0]                            tag;
        logic [DEF_WORDS_PER_LINE-1:0][DEF_XLEN-1:0]     data;
    } line_t;

endpackage

// File: rtl/dcache_array.sv
// Tag, valid and data storage: one combinational read port, one synchronous write port.
// Only the valid bits are reset; tag and data contents survive reset.
module dcache_array
    import dcache_pkg::*;
#(
    parameter int XLEN           = DEF_XLEN,
    parameter int NUM_LINES      = DEF_NUM_LINES,
    parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE,
    parameter int IDX_W          = idx_w(NUM_LINES),
    parameter int OFF_W          = off_w(WORDS_PER_LINE),
    parameter int TAG_W          = tag_w(XLEN, NUM_LINES, WORDS_PER_LINE)
) (
    input  logic                                   clk,
    input  logic                                   rst_b,
    input  logic [IDX_W-1:0]                       rd_idx,
    output logic                                   rd_valid,
    output logic [TAG_W-1:0]                       rd_tag,
    output logic [WORDS_PER_LINE-1:0][XLEN-1:0]    rd_data,
    input  logic [IDX_W-1:0]                       wr_idx,
    input  logic                                   wr_word_en,
    input  logic [OFF_W-1:0]                       wr_off,
    input  logic [XLEN-1:0]                        wr_data,
    input  logic                                   wr_tag_en,
    input  logic [TAG_W-1:0]                       wr_tag
);

    logic [NUM_LINES-1:0]                  valid;
    logic [TAG_W-1:0]                      tags [NUM_LINES];
    logic [WORDS_PER_LINE-1:0][XLEN-1:0]   data [NUM_LINES];

    assign rd_valid = valid[rd_idx];
    assign rd_tag   = tags[rd_idx];
    assign rd_data  = data[rd_idx];

    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b)
            valid <= '0;
        else if (wr_tag_en)
            valid[wr_idx] <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (wr_tag_en)
            tags[wr_idx] <= wr_tag;
        if (wr_word_en)
            data[wr_idx][wr_off] <= wr_data;
    end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller behind the MEM stage.
// Define DCACHE_STATS_EN to add saturating hit_count / miss_count outputs.
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int XLEN           = DEF_XLEN,
    parameter int NUM_LINES      = DEF_NUM_LINES,
    parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic [XLEN-1:0]   cpu_addr,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [7:0]        cpu_wdata [0:3],
    output logic [7:0]        cpu_rdata [0:3],
    output logic              cpu_stall,
    output logic              cpu_reg_we,
    output logic              mem_req,
    output logic              mem_we,
    output logic [XLEN-1:0]   mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic [XLEN-1:0]   mem_rdata,
    input  logic              mem_ready
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
`endif
);

    localparam int OFF_W = off_w(WORDS_PER_LINE);
    localparam int IDX_W = idx_w(NUM_LINES);
    localparam int TAG_W = tag_w(XLEN, NUM_LINES, WORDS_PER_LINE);
    localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(WORDS_PER_LINE - 1);

    state_t              state;
    logic [XLEN-3:0]     addr_q;
    logic [OFF_W-1:0]    cnt;
    logic [OFF_W-1:0]    cnt_nxt;

    logic [OFF_W-1:0]    c_off, q_off, rd_off;
    logic [IDX_W-1:0]    c_idx, q_idx, rd_idx;
    logic [TAG_W-1:0]    c_tag, q_tag;
    logic [1:0]          unused_addr_bits;

    assign c_off = cpu_addr[2 +: OFF_W];
    assign c_idx = cpu_addr[2+OFF_W +: IDX_W];
    assign c_tag = cpu_addr[XLEN-1 -: TAG_W];
    assign q_off = addr_q[0 +: OFF_W];
    assign q_idx = addr_q[OFF_W +: IDX_W];
    assign q_tag = addr_q[XLEN-3 -: TAG_W];
    assign unused_addr_bits = cpu_addr[1:0];
    assign cnt_nxt = cnt + 1'b1;

    logic                                 rd_valid;
    logic [TAG_W-1:0]                     rd_tag;
    logic [WORDS_PER_LINE-1:0][XLEN-1:0]  rd_data;
    logic [XLEN-1:0]                      rd_word;
    logic                                 hit_now, q_hit;
    logic                                 wr_word_en, wr_tag_en;
    logic [OFF_W-1:0]                     wr_off;
    logic [XLEN-1:0]                      wr_data;
    logic [XLEN-1:0]                      wdata_word;
    logic [XLEN-1:0]                      rdata_word;

    // Lookups in IDLE use the live address; every other state works on the latched copy.
    assign rd_idx  = (state == IDLE) ? c_idx : q_idx;
    assign rd_off  = (state == IDLE) ? c_off : q_off;
    assign rd_word = rd_data[rd_off];
    assign hit_now = rd_valid && (rd_tag == c_tag);
    assign q_hit   = rd_valid && (rd_tag == q_tag);

    assign wr_word_en = mem_ready && ((state == REFILL) || ((state == WRITE) && q_hit));
    assign wr_tag_en  = mem_ready && (state == REFILL) && (cnt == LAST_WORD);
    assign wr_off     = (state == REFILL) ? cnt : q_off;
    assign wr_data    = (state == REFILL) ? mem_rdata : mem_wdata;

    dcache_array #(
        .XLEN           (XLEN),
        .NUM_LINES      (NUM_LINES),
        .WORDS_PER_LINE (WORDS_PER_LINE),
        .IDX_W          (IDX_W),
        .OFF_W          (OFF_W),
        .TAG_W          (TAG_W)
    ) u_array (
        .clk        (clk),
        .rst_b      (rst_b),
        .rd_idx     (rd_idx),
        .rd_valid   (rd_valid),
        .rd_tag     (rd_tag),
        .rd_data    (rd_data),
        .wr_idx     (q_idx),
        .wr_word_en (wr_word_en),
        .wr_off     (wr_off),
        .wr_data    (wr_data),
        .wr_tag_en  (wr_tag_en),
        .wr_tag     (q_tag)
    );

    always_comb begin
        wdata_word = '0;
        for (int b = 0; b < 4; b++)
            wdata_word[8*b +: 8] = cpu_wdata[b];
    end

    // Store stall drops in the mem_ready cycle so the pipeline retires the store on that
    // same edge and does not present it to IDLE a second time.
    always_comb begin
        cpu_stall  = 1'b0;
        rdata_word = '0;
        case (state)
            IDLE: begin
                if (cpu_wr)
                    cpu_stall = 1'b1;
                else if (cpu_rd) begin
                    if (hit_now)
                        rdata_word = rd_word;
                    else
                        cpu_stall = 1'b1;
                end
            end
            REFILL: cpu_stall = 1'b1;
            WRITE:  cpu_stall = !mem_ready;
            DONE:   rdata_word = rd_word;
            default: cpu_stall = 1'b0;
        endcase
        if (rst_b) begin
            cpu_stall  = 1'b0;
            rdata_word = '0;
        end
    end

    always_comb begin
        for (int b = 0; b < 4; b++)
            cpu_rdata[b] = rdata_word[8*b +: 8];
    end

    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            state      <= IDLE;
            addr_q     <= '0;
            cnt        <= '0;
            cpu_reg_we <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            cpu_reg_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu_wr) begin
                        state     <= WRITE;
                        addr_q    <= cpu_addr[XLEN-1:2];
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= {cpu_addr[XLEN-1:2], 2'b00};
                        mem_wdata <= wdata_word;
                    end else if (cpu_rd && !hit_now) begin
                        state    <= REFILL;
                        addr_q   <= cpu_addr[XLEN-1:2];
                        cnt      <= '0;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= {c_tag, c_idx, {OFF_W{1'b0}}, 2'b00};
                    end
                end
                REFILL: begin
                    if (mem_ready) begin
                        cnt <= cnt_nxt;
                        if (cnt == LAST_WORD) begin
                            state      <= DONE;
                            mem_req    <= 1'b0;
                            cpu_reg_we <= 1'b1;
                        end else begin
                            mem_addr <= {q_tag, q_idx, cnt_nxt, 2'b00};
                        end
                    end
                end
                WRITE: begin
                    if (mem_ready) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DCACHE_STATS_EN
    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (state == IDLE && !cpu_wr && cpu_rd) begin
            if (hit_now && hit_count != 32'hFFFF_FFFF)
                hit_count <= hit_count + 32'd1;
            if (!hit_now && miss_count != 32'hFFFF_FFFF)
                miss_count <= miss_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Bench for dcache_ctrl: directed scenarios plus random traffic against a transaction-level model.
// Works with or without DCACHE_STATS_EN defined.
module tb_dcache_ctrl;

    localparam int NL  = 8;
    localparam int WPL = 4;

    logic        clk = 1'b0;
    logic        rst_b = 1'b0;
    logic [31:0] cpu_addr = '0;
    logic        cpu_rd = 1'b0;
    logic        cpu_wr = 1'b0;
    logic [7:0]  cpu_wdata [0:3];
    logic [7:0]  cpu_rdata [0:3];
    logic        cpu_stall, cpu_reg_we, mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ready = 1'b0;
`ifdef DCACHE_STATS_EN
    logic [31:0] hit_count, miss_count;
`endif

    dcache_ctrl dut (
        .clk        (clk),
        .rst_b      (rst_b),
        .cpu_addr   (cpu_addr),
        .cpu_rd     (cpu_rd),
        .cpu_wr     (cpu_wr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_stall  (cpu_stall),
        .cpu_reg_we (cpu_reg_we),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready)
`ifdef DCACHE_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, got, exp, $time);
        end
    endtask

    // Main memory: untouched words have an address-derived pattern.
    bit [31:0] mem [bit [31:0]];
    function automatic bit [31:0] mem_rd(input bit [31:0] a);
        if (mem.exists(a)) return mem[a];
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic int a_idx(input bit [31:0] a); return int'((a >> 4) & 32'h7); endfunction
    function automatic int a_off(input bit [31:0] a); return int'((a >> 2) & 32'h3); endfunction
    function automatic bit [31:0] a_tag(input bit [31:0] a); return a >> 7; endfunction

    // Model: cache contents as plain arrays plus the outstanding access (if any).
    bit          mv [NL];
    bit [31:0]   mt [NL];
    bit [31:0]   md [NL][WPL];
    bit [31:0]   lbuf [WPL];
    int          phase = 0;          // 0 free, 1 fetching line, 2 load complete, 3 store pending
    int          fw = 0;
    bit [31:0]   m_addr, m_wd;
    int unsigned m_hits = 0, m_miss = 0;

    function automatic bit m_hit(input bit [31:0] a);
        return mv[a_idx(a)] && (mt[a_idx(a)] == a_tag(a));
    endfunction

    // Memory responder: random or fixed latency, optional stray mem_ready while idle.
    typedef struct { bit [31:0] addr; bit we; bit [31:0] wdata; } mlog_t;
    mlog_t mlog[$];
    int    req_wait = 0, cur_lat = 0, lat_fixed = 0, req_cycles = 0;
    bit    spurious_en = 1'b0;

    always @(negedge clk) begin
        mem_ready = 1'b0;
        if (rst_b) begin
            req_wait = 0;
        end else if (mem_req) begin
            req_cycles++;
            if (req_wait == 0) cur_lat = (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(0, 3));
            if (req_wait >= cur_lat) begin
                mem_ready = 1'b1;
                mem_rdata = mem_rd(mem_addr);
                mlog.push_back('{mem_addr, mem_we, mem_wdata});
                req_wait = 0;
            end else begin
                req_wait++;
            end
        end else begin
            req_wait = 0;
            if (spurious_en && $urandom_range(0, 3) == 0) begin
                mem_ready = 1'b1;
                mem_rdata = $urandom;
            end
        end
    end

    // Compare process: checks every cycle, then advances the model across the coming edge.
    always @(negedge clk) begin
        bit [31:0] a, exp_a, wd, rd;
        #1;
        rd = {cpu_rdata[3], cpu_rdata[2], cpu_rdata[1], cpu_rdata[0]};
        wd = {cpu_wdata[3], cpu_wdata[2], cpu_wdata[1], cpu_wdata[0]};
        if (rst_b) begin
            check("rst_stall", cpu_stall, 0);
            check("rst_regwe", cpu_reg_we, 0);
            check("rst_req", mem_req, 0);
            check("rst_we", mem_we, 0);
            check("rst_maddr", mem_addr, 0);
            check("rst_mwdata", mem_wdata, 0);
            check("rst_rdata", rd, 0);
`ifdef DCACHE_STATS_EN
            check("rst_hits", hit_count, 0);
            check("rst_miss", miss_count, 0);
`endif
            for (int i = 0; i < NL; i++) mv[i] = 1'b0;
            phase = 0; m_hits = 0; m_miss = 0;
        end else begin
`ifdef DCACHE_STATS_EN
            check("hit_count", hit_count, m_hits);
            check("miss_count", miss_count, m_miss);
`endif
            case (phase)
                0: begin
                    check("idle_req", mem_req, 0);
                    check("idle_regwe", cpu_reg_we, 0);
                    a = {cpu_addr[31:2], 2'b00};
                    if (cpu_wr) begin
                        check("wr_stall", cpu_stall, 1);
                        phase = 3; m_addr = a; m_wd = wd;
                    end else if (cpu_rd) begin
                        if (m_hit(a)) begin
                            check("hit_stall", cpu_stall, 0);
                            check("hit_rdata", rd, md[a_idx(a)][a_off(a)]);
                            if (m_hits != 32'hFFFF_FFFF) m_hits++;
                        end else begin
                            check("miss_stall", cpu_stall, 1);
                            phase = 1; fw = 0; m_addr = a;
                            if (m_miss != 32'hFFFF_FFFF) m_miss++;
                        end
                    end else begin
                        check("idle_stall", cpu_stall, 0);
                    end
                end
                1: begin
                    exp_a = (m_addr & ~32'hF) + 32'(4 * fw);
                    check("fill_stall", cpu_stall, 1);
                    check("fill_req", mem_req, 1);
                    check("fill_we", mem_we, 0);
                    check("fill_addr", mem_addr, exp_a);
                    check("fill_regwe", cpu_reg_we, 0);
                    if (mem_ready) begin
                        lbuf[fw] = mem_rd(exp_a);
                        fw++;
                        if (fw == WPL) begin
                            mv[a_idx(m_addr)] = 1'b1;
                            mt[a_idx(m_addr)] = a_tag(m_addr);
                            for (int w = 0; w < WPL; w++) md[a_idx(m_addr)][w] = lbuf[w];
                            phase = 2;
                        end
                    end
                end
                2: begin
                    check("done_stall", cpu_stall, 0);
                    check("done_regwe", cpu_reg_we, 1);
                    check("done_req", mem_req, 0);
                    check("done_rdata", rd, md[a_idx(m_addr)][a_off(m_addr)]);
                    phase = 0;
                end
                default: begin
                    check("st_req", mem_req, 1);
                    check("st_we", mem_we, 1);
                    check("st_addr", mem_addr, m_addr);
                    check("st_wdata", mem_wdata, m_wd);
                    check("st_stall", cpu_stall, {31'd0, !mem_ready});
                    check("st_regwe", cpu_reg_we, 0);
                    if (mem_ready) begin
                        mem[m_addr] = m_wd;
                        if (m_hit(m_addr)) md[a_idx(m_addr)][a_off(m_addr)] = m_wd;
                        phase = 0;
                    end
                end
            endcase
        end
    end

    // Presents one access and holds it until the controller stops stalling.
    task automatic do_access(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                             output logic [31:0] rdata, output int stalls, output bit regwe);
        cpu_addr = a; cpu_rd = rd; cpu_wr = wr;
        for (int b = 0; b < 4; b++) cpu_wdata[b] = wd[8*b +: 8];
        stalls = 0; rdata = '0; regwe = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk); #2;
            if (!cpu_stall) begin
                rdata = {cpu_rdata[3], cpu_rdata[2], cpu_rdata[1], cpu_rdata[0]};
                regwe = cpu_reg_we;
                break;
            end
            stalls++;
            if (i == 199) check("access_timeout", cpu_stall, 0);
        end
        @(posedge clk); #1;
        cpu_rd = 1'b0; cpu_wr = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rdat;
        int          st, rc0, base;
        bit          rwe;
        bit [31:0]   exp_seq [4];
        bit [31:0]   ra, rw;
        exp_seq = '{32'h40, 32'h44, 32'h48, 32'h4C};

        for (int b = 0; b < 4; b++) cpu_wdata[b] = 8'h00;
        #1 rst_b = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("lit_rst_stall", cpu_stall, 0);
        check("lit_rst_req", mem_req, 0);
        rst_b = 1'b0;
        mem[32'h40] = 32'h11; mem[32'h44] = 32'h22; mem[32'h48] = 32'h33; mem[32'h4C] = 32'h44;
        @(posedge clk); #1;

        // Cold miss with single-cycle memory.
        lat_fixed = 0; mlog.delete();
        do_access(1, 0, 32'h40, 0, rdat, st, rwe);
        check("lit_refill_data", rdat, 32'h11);
        check("lit_refill_regwe", rwe, 1);
        check("lit_refill_stall_ge4", st >= 4, 1);
        check("lit_refill_nreq", mlog.size(), 4);
        for (int i = 0; i < 4 && i < mlog.size(); i++) check("lit_refill_addr", mlog[i].addr, exp_seq[i]);

        // Same-line hit: no stall, no memory traffic.
        rc0 = req_cycles;
        do_access(1, 0, 32'h48, 0, rdat, st, rwe);
        check("lit_hit_data", rdat, 32'h33);
        check("lit_hit_stall", st, 0);
        check("lit_hit_noreq", req_cycles - rc0, 0);

        // Store hit with 3-cycle memory delay.
        lat_fixed = 3; mlog.delete();
        do_access(0, 1, 32'h44, 32'hDEADBEEF, rdat, st, rwe);
        check("lit_st_stall", st, 4);
        check("lit_st_we", mlog.size() > 0 ? mlog[0].we : 1'b0, 1);
        check("lit_st_addr", mlog.size() > 0 ? mlog[0].addr : 32'h0, 32'h44);
        check("lit_st_wdata", mlog.size() > 0 ? mlog[0].wdata : 32'h0, 32'hDEADBEEF);
        lat_fixed = 0;
        do_access(1, 0, 32'h44, 0, rdat, st, rwe);
        check("lit_st_readback", rdat, 32'hDEADBEEF);
        check("lit_st_readback_stall", st, 0);

        // Store miss does not allocate.
        do_access(0, 1, 32'h200, 32'hCAFEF00D, rdat, st, rwe);
        do_access(1, 0, 32'h200, 0, rdat, st, rwe);
        check("lit_noalloc_miss", st > 0, 1);
        check("lit_noalloc_data", rdat, 32'hCAFEF00D);

        // Conflict on index 4 evicts the 0x40 line.
        do_access(1, 0, 32'h240, 0, rdat, st, rwe);
        check("lit_conflict_miss", st > 0, 1);
        do_access(1, 0, 32'h40, 0, rdat, st, rwe);
        check("lit_evicted_miss", st > 0, 1);
        check("lit_evicted_data", rdat, 32'h11);

        // Reset while the second refill word is outstanding.
        lat_fixed = 1; base = mlog.size();
        cpu_addr = 32'h240; cpu_rd = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk); #2;
            if (mlog.size() == base + 1) break;
        end
        @(posedge clk); #2;
        check("lit_mid_addr", mem_addr, 32'h244);
        rst_b = 1'b1;
        #1;
        check("lit_mid_rst_req", mem_req, 0);
        check("lit_mid_rst_stall", cpu_stall, 0);
        cpu_rd = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_b = 1'b0;
`ifdef DCACHE_STATS_EN
        check("lit_stats_hits0", hit_count, 0);
        check("lit_stats_miss0", miss_count, 0);
`endif
        lat_fixed = 0;
        do_access(1, 0, 32'h40, 0, rdat, st, rwe);
        check("lit_post_rst_miss", st > 0, 1);
        check("lit_post_rst_data", rdat, 32'h11);

        // Random traffic over a small address pool to provoke hits, conflicts and store hits.
        lat_fixed = -1; spurious_en = 1'b1;
        for (int n = 0; n < 400; n++) begin
            int k;
            k  = int'($urandom_range(0, 99));
            ra = ({30'd0, 2'($urandom_range(0, 3))} << 7) | (32'($urandom_range(0, 7)) << 4)
               | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
            rw = $urandom;
            if (k < 45)      do_access(1, 0, ra, rw, rdat, st, rwe);
            else if (k < 80) do_access(0, 1, ra, rw, rdat, st, rwe);
            else if (k < 90) do_access(1, 1, ra, rw, rdat, st, rwe);
            else if (k < 98) begin @(posedge clk); #1; end
            else begin
                rst_b = 1'b1;
                @(posedge clk); #1;
                rst_b = 1'b0;
            end
        end
        spurious_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
Direct-mapped, write-through, no-write-allocate data cache controller. Sits directly downstream of the pipeline MEM stage: it takes the MEM-stage address, store data, read and write strobes, and returns load data plus a stall. On a miss it refills a whole line from main memory over a word-wide request/ready handshake. Its cpu_reg_we output drives the pipeline's cache register-write-enable input, so a load that completes after a refill still retires its writeback.

Parameters:
XLEN, 32, data and address width.
NUM_LINES, 8, number of cache lines; must be a power of two and at least 2.
WORDS_PER_LINE, 4, words per line; must be a power of two and at least 2.

Ports:
clk  input  1  clock; all state updates on posedge.
rst_b  input  1  asynchronous reset, active-high (asserted = 1), despite the port name.
cpu_addr  input  XLEN  MEM-stage byte address; bits [1:0] are ignored.
cpu_rd  input  1  load request.
cpu_wr  input  1  store request.
cpu_wdata  input  [7:0] x [0:3]  store data; element [0] is the least significant byte.
cpu_rdata  output  [7:0] x [0:3]  load data, same byte order as cpu_wdata.
cpu_stall  output  1  stall request to the pipeline, held while the access is unresolved.
cpu_reg_we  output  1  one-cycle pulse: refilled load data is valid this cycle.
mem_req  output  1  main-memory request.
mem_we  output  1  1 = write, 0 = read.
mem_addr  output  XLEN  word-aligned memory address.
mem_wdata  output  XLEN  write data to memory.
mem_rdata  input  XLEN  read data from memory.
mem_ready  input  1  memory completes the current request this cycle.

Behaviour:
- Address split:
  - word offset = addr[1+log2(WORDS_PER_LINE):2]
  - index = next log2(NUM_LINES) bits
  - tag = remaining upper bits
- Reset values: all valid bits 0, FSM = IDLE, cpu_stall 0, cpu_reg_we 0, mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0, cpu_rdata 0.
- Line data is not reset.
- FSM states: IDLE, REFILL, WRITE, DONE.
- IDLE, read hit (valid && tag match):
  - cpu_rdata driven combinationally the same cycle.
  - cpu_stall 0, cpu_reg_we 0; zero added latency.
- IDLE, read miss:
  - cpu_stall asserts combinationally in the same cycle; next state REFILL with word counter = 0.
- REFILL:
  - mem_req=1, mem_we=0, mem_addr = {tag, index, counter, 2'b00}, fetching words 0..WORDS_PER_LINE-1 in order.
  - Each request is held until mem_ready; on mem_ready the word is stored and the counter increments.
  - On the last mem_ready: write tag, set valid, go to DONE.
  - cpu_stall stays 1 throughout.
- DONE (exactly one cycle):
  - cpu_stall 0, cpu_reg_we 1, cpu_rdata = requested word from the refilled line; next state IDLE.
- IDLE with cpu_wr (hit or miss):
  - Go to WRITE, cpu_stall 1.
  - mem_req=1, mem_we=1, mem_addr = {addr[XLEN-1:2], 2'b00}, mem_wdata = packed cpu_wdata.
  - Requests are registered; mem_req rises the cycle after entering WRITE is decided.
- WRITE:
  - Hold the request until mem_ready.
  - On mem_ready: if the line is a hit, update that cache word the same edge; return to IDLE with cpu_stall 0.
  - A write miss does not allocate.
- cpu_rd and cpu_wr both high: treated as a write; the read is ignored.
- mem_ready while mem_req=0 is ignored.
- The CPU must hold its address, strobes and data stable while cpu_stall=1. The controller latches the address at the start of a miss or write and uses the latched copy throughout.
- Reset asserted mid-REFILL or mid-WRITE: immediate return to IDLE, mem_req drops asynchronously, all valid bits cleared, the partial line is discarded.
- A store never invalidates a line; a store hit keeps cache and memory coherent.

Optional Feature:
DCACHE_STATS_EN
- Defined: adds 32-bit output ports hit_count and miss_count, reset to 0.
  - hit_count increments on each IDLE read hit.
  - miss_count increments on each IDLE-to-REFILL transition.
  - Both saturate at 32'hFFFF_FFFF.
  - Stores are not counted.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package dcache_pkg holds:
  - state_t enum (IDLE, REFILL, WRITE, DONE)
  - localparam functions for offset, index and tag widths
  - line_t packed struct {valid, tag, data[WORDS_PER_LINE]}
- Sub-module dcache_array: tag, valid and data storage.
  - One combinational read port by index.
  - One synchronous write port: word write, or tag+valid write.
  - Asynchronous valid clear on rst_b.

Test Plan:
- Read 0x40 after reset; memory returns 0x11, 0x22, 0x33, 0x44 for 0x40..0x4C, one-cycle ready each -> cpu_stall high 4+ cycles, mem_addr steps 0x40, 0x44, 0x48, 0x4C, DONE cycle with cpu_reg_we=1 and cpu_rdata=0x11.
- Then read 0x48 -> same-cycle hit, cpu_rdata=0x33, cpu_stall=0, no mem_req.
- Write 0xDEADBEEF to 0x44 (hit), mem_ready delayed 3 cycles -> mem_we=1, stall held until ready; a later read of 0x44 hits with 0xDEADBEEF.
- Write to 0x200 (miss), then read 0x200 -> write-through with no allocate; the read misses and refills.
- Read 0x240 (same index as 0x40, different tag) -> miss, line replaced; a later read of 0x40 misses again.
- Assert rst_b during the 2nd refill word -> mem_req=0 immediately; after release, a read of 0x40 misses and refills again. With DCACHE_STATS_EN, counters read 0.
